msk_state_loader: RTL

- Streams a masked state from the software interface into the masked Clyde core.
- Accepts W-bit words in share-major order: all of share 0, then share 1, and so on.
- Buffers one complete d-share state, then presents it bit-interleaved in the order the masking gadgets expect, over a valid/ready handshake.
- Sits between the bus/FIFO word interface and the core state-load port. Owns word counting, framing check, back-pressure and abort.

---
 rtl/msk_state_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/msk_state_loader.sv
// Collects a share-major stream of W-bit words into a d-share masked state and
// presents it bit-interleaved (share 0 at the MSB of each d-bit group) to the Clyde core.
module msk_state_loader #(
    parameter int Nbits = 128,
    parameter int d     = 2,
    parameter int W     = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_abort,
    input  logic [W-1:0]                     i_din,
    input  logic                             i_din_valid,
    input  logic                             i_din_last,
    output logic                             o_din_ready,
    output logic [d*Nbits-1:0]               o_state_out,
    output logic                             o_state_valid,
    input  logic                             i_state_ready,
    output logic [$clog2(d*Nbits/W):0]       o_word_cnt,
    output logic                             o_frame_err
);

    localparam int WPS = Nbits / W;
    localparam int NW  = d * WPS;
    localparam int CW  = $clog2(NW) + 1;
    localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

    generate
        if ((Nbits % W) != 0) begin : g_bad_width
            $error("msk_state_loader: Nbits must be a multiple of W");
        end
    endgenerate

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_buf [NW];
    logic [CW-1:0]   r_wordCnt;
    logic            r_stateValid;
    logic            r_frameErr;

    logic [IW-1:0]   w_slot;
    logic            w_isLast;

    // Word k lands in r_buf[k]; since every share is WPS words, k also encodes the share index.
    assign w_slot   = r_wordCnt[IW-1:0];
    assign w_isLast = (r_wordCnt == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_abort) begin
            r_state      <= LOAD;
            r_wordCnt    <= '0;
            r_stateValid <= 1'b0;
            r_frameErr   <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (i_din_valid) begin
                        r_buf[w_slot] <= i_din;
                        r_wordCnt     <= r_wordCnt + CW'(1);
                        // A misplaced or missing last flag is recorded but never shortens the frame.
                        if (i_din_last != w_isLast) begin
                            r_frameErr <= 1'b1;
                        end
                        if (w_isLast) begin
                            r_state      <= FULL;
                            r_stateValid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (i_state_ready) begin
                        r_state      <= LOAD;
                        r_wordCnt    <= '0;
                        r_stateValid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign o_din_ready   = (r_state == LOAD) && i_rst_n;
    assign o_state_valid = r_stateValid;
    assign o_word_cnt    = r_wordCnt;
    assign o_frame_err   = r_frameErr;

    always_comb begin
        o_state_out = '0;
        for (int i = 0; i < d; i++) begin
            for (int b = 0; b < Nbits; b++) begin
                o_state_out[b*d + d-1-i] = r_buf[i*WPS + b/W][b%W];
            end
        end
    end

endmodule
